apb_master_arb: RTL
===================

# apb_master_arb

Two-requester APB master sequencer for the AHB2APB subsystem. It takes single read/write requests from two on-chip requesters, picks one with round-robin arbitration, and drives one APB transfer at a time through the SETUP and ACCESS phases. It returns read data or an error to the requester that was granted, and aborts any slave that stalls for too long.

## Interface
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, maximum ACCESS cycles without pready before the transfer is aborted; 0 disables the timeout
- hclk  in  1  clock; all state changes on the rising edge
- hreset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_write  in  2  per-requester direction; 1 = write
- req_addr  in  2*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  2*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  2  request accepted; combinational, one-hot or zero
- rsp_valid  out  2  one-cycle response pulse to the granted requester
- rsp_rdata  out  DATA_W  read data; qualified by rsp_valid
- rsp_err  out  1  error flag; qualified by rsp_valid
- psel, penable, pwrite  out  1  APB control signals
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready, pslverr  in  1  APB slave handshake and error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - Arbitration is combinational. If both requesters are valid, grant the one that is not `last_grant`. If only one is valid, grant it.
  - req_ready[g] = 1 only in IDLE, only for the granted g.
  - Handshake completes on an edge where req_valid[g] & req_ready[g] is high. On that edge:
    - latch write, addr and wdata from requester g
    - update last_grant to g
    - move to SETUP
- **SETUP:** psel=1, penable=0. Move to ACCESS unconditionally.
- **ACCESS:** psel=1, penable=1. Timeout counter starts at 0 on entry.
  - pready=1: capture prdata (forced to 0 for writes) and pslverr. On the next edge, rsp_valid[g]=1 for one cycle and the FSM returns to IDLE.
  - pready=0 and count == TIMEOUT-1 (TIMEOUT≠0): abort. Next cycle rsp_valid[g]=1, rsp_err=1, rsp_rdata=0, FSM returns to IDLE.
  - pready=0 otherwise: increment the counter and stay in ACCESS.
  - If pready and the timeout condition occur in the same cycle, pready wins and the transfer completes normally.
- paddr, pwrite and pwdata stay stable from SETUP through the last ACCESS cycle. Outside a transfer they hold their last value.
- Requesters must keep valid and payload stable until ready. The block does not check this.
- pslverr is ignored when pready=0.

## Timing
- Reset values: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. State = IDLE, last_grant=1 (so requester 0 wins the first tie), counter=0.
- Zero-wait-state transfer, acceptance at edge T:
  - T+1: SETUP
  - T+2: ACCESS, with pready=1
  - T+3: rsp_valid high and FSM in IDLE
- Because the FSM is in IDLE at T+3, a new request can be accepted in that same cycle. Back-to-back throughput is therefore one transfer per 3 cycles.
- Each wait state adds one cycle.
- A timeout response appears one cycle after the TIMEOUT-th ACCESS cycle.
- hreset asserted mid-transfer:
  - psel and penable go to 0 at the next edge
  - no response is issued
  - arbitration restarts with requester 0 priority

## Test plan
- **Single read, no wait states:** requester 0 reads 0x40, prdata=0xDEADBEEF, pready=1. Expect psel high for 2 cycles, penable in the second; rsp_valid=2'b01 at T+3 with rdata 0xDEADBEEF and err=0.
- **Tie arbitration:** both requesters valid from reset (writes to 0x10 and 0x20). Expect requester 0 granted first, then requester 1. With both held valid continuously, grants alternate 0,1,0,1 across 4 transfers.
- **Wait states and error:** requester 1 writes 0x55 to 0x8, pready low for 3 ACCESS cycles, then high with pslverr=1. Expect paddr/pwdata stable throughout; rsp_valid=2'b10 with err=1 and rdata=0.
- **Timeout:** TIMEOUT=4, pready held at 0. Expect exactly 4 ACCESS cycles, then psel=0 and rsp_err=1 on requester 0's response. Repeat with pready=1 on the 4th ACCESS cycle and expect a normal completion.
- **Reset mid-ACCESS:** assert hreset while in ACCESS. Expect psel=penable=0 the next cycle and no rsp_valid. After release, requester 0 wins a tie.
- **Back-to-back:** requester 0 keeps valid high across 3 reads. Expect acceptances exactly 3 cycles apart, each coinciding with the previous rsp_valid pulse.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// Request/response and APB bus bundle for the two-requester APB master sequencer.
interface apb_master_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [ADDR_W-1:0]   paddr;
  logic [DATA_W-1:0]   pwdata;
  logic [DATA_W-1:0]   prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// Round-robin arbiter for two requesters driving one APB transfer at a time,
// with an ACCESS-phase timeout that aborts a stalled slave.
//
// state  | meaning
// IDLE   | arbitrate, accept one request
// SETUP  | psel=1, penable=0
// ACCESS | psel=1, penable=1, wait for pready or timeout
module apb_master_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic hclk,
  input  logic hreset,
  apb_master_arb_if.master bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              last_grant, cur_grant, grant;
  logic              accept, timeout_hit;
  logic [CNT_W-1:0]  cnt;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant = 1'b0;
    if (&bus.req_valid) grant = ~last_grant;
    else if (bus.req_valid[1]) grant = 1'b1;
  end

  assign accept      = (state == IDLE) && (|bus.req_valid) && !hreset;
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.pready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_grant   <= 1'b0;
      cnt         <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= 2'b00;
      if (accept) begin
        last_grant <= grant;
        cur_grant  <= grant;
        pwrite_q   <= bus.req_write[grant];
        paddr_q    <= grant ? bus.req_addr[2*ADDR_W-1:ADDR_W] : bus.req_addr[ADDR_W-1:0];
        pwdata_q   <= grant ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
      end
      if (state == SETUP) cnt <= '0;
      if (state == ACCESS) begin
        // pready takes priority over a coincident timeout
        if (bus.pready) begin
          rsp_valid_q <= cur_grant ? 2'b10 : 2'b01;
          rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          rsp_err_q   <= bus.pslverr;
        end else if (timeout_hit) begin
          rsp_valid_q <= cur_grant ? 2'b10 : 2'b01;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.psel      = (state != IDLE);
  assign bus.penable   = (state == ACCESS);
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
